pu_stream_array: RTL
====================

Name: pu_stream_array

Overview:
- Next-generation processing unit: MAC_NUM parallel signed multiply-accumulate lanes.
- Fixed-length accumulation (ACC_LEN beats) under an in/out valid-ready handshake.
- One-entry output buffer so the next block accumulates while a result waits.
- Output stage: arithmetic right-shift requantisation; sits between the activation/weight streamer and the writeback/post-processing stage.

Parameters:
DATA_WIDTH, 8, bits per signed activation element
WEIGHT_WIDTH, 8, bits per signed weight
MAC_NUM, 8, number of lanes
ACC_WIDTH, 32, internal accumulator width per lane (>= DATA_WIDTH+WEIGHT_WIDTH)
OUT_WIDTH, 16, output width per lane (<= ACC_WIDTH)
ACC_LEN, 16, input beats summed per result (>= 1)
SHIFT, 0, arithmetic right shift applied before output truncation/saturation
WEIGHT_SHARED, 1, 1 = one weight broadcast to all lanes; 0 = one weight per lane

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
en_i  in  1  global enable; 0 forces in_ready_o low
clear_i  in  1  synchronous clear of accumulators and beat counter
in_valid_i  in  1  input beat valid
in_ready_o  out  1  input beat accepted when in_valid_i & in_ready_o
din_i  in  DATA_WIDTH*MAC_NUM  signed activations; lane i at [i*DATA_WIDTH +: DATA_WIDTH]
win_i  in  WEIGHT_WIDTH*(WEIGHT_SHARED?1:MAC_NUM)  signed weight(s); lane i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
out_valid_o  out  1  result buffer holds a result
out_ready_i  in  1  downstream accepts result
out_data_o  out  OUT_WIDTH*MAC_NUM  results; lane i at [i*OUT_WIDTH +: OUT_WIDTH]
sat_o  out  MAC_NUM  per-lane saturation flag for the buffered result
busy_o  out  1  accumulation FSM in S_ACCUM

Behaviour:
- Reset (rst_i high, asynchronous): accumulators 0, beat counter 0, FSM S_IDLE, out_valid_o 0, out_data_o 0, sat_o 0, busy_o 0.
- Product: full-precision signed DATA_WIDTH+WEIGHT_WIDTH bits, sign-extended to ACC_WIDTH.
- Accumulation wraps in two's complement at ACC_WIDTH; no overflow detection inside the accumulator.
- Accumulation FSM:
  - S_IDLE: counter 0, accumulators 0. Accepted beat -> S_ACCUM, or stays in S_IDLE when ACC_LEN==1.
  - S_ACCUM: each accepted beat adds its product and increments the counter.
  - Beat accepted with counter==ACC_LEN-1 ("last beat"): acc+product is requantised into the output buffer, out_valid_o=1 next cycle; accumulators and counter return to 0; FSM -> S_IDLE. No bubble: the next beat may be accepted the following cycle.
- in_ready_o (combinational) = en_i & ~clear_i & ~(counter==ACC_LEN-1 & out_valid_o & ~out_ready_i). Only the last beat stalls on a full buffer.
- Output buffer:
  - Pop when out_valid_o & out_ready_i.
  - Pop and last-beat push in the same cycle: buffer reloads, out_valid_o stays 1.
  - out_data_o and sat_o are stable while out_valid_o=1 and not popped.
- Requantisation: lane value = acc >>> SHIFT, then low OUT_WIDTH bits (truncation) unless PU_SAT_EN is defined.
- clear_i: next cycle accumulators 0, counter 0, FSM S_IDLE. Input is not accepted that cycle (in_ready_o=0). The output buffer and a pending result are untouched.
- en_i=0: holds all state; output handshake still operates.
- Counter width $clog2(ACC_LEN), minimum 1.

Optional Feature:
- Macro PU_SAT_EN.
- Defined: after the shift, each lane saturates to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; sat_o[i]=1 when lane i clipped, registered with the result.
- Undefined: plain truncation; sat_o tied to 0.

Decomposition:
- Package pu_pkg:
  - FSM state type (S_IDLE, S_ACCUM).
  - Counter-width helper function.
  - Saturate/requantise function taking (value, SHIFT, OUT_WIDTH).
- Sub-module pu_lane: one multiply-accumulate lane (product, accumulator, clear, load-zero-on-last). Instantiated MAC_NUM times by generate.
- Top level owns the FSM, counter, handshake and output buffer.

Test Plan:
- ACC_LEN=4, shared weight: feed din lanes all 3, weight 2, 4 beats, out_ready_i=1 -> one out_valid_o pulse one cycle after last beat, every lane 24; busy_o high during beats 1-3.
- Back-to-back blocks, out_ready_i=0 for 10 cycles: second block's beats 0-2 accepted, beat 3 stalls (in_ready_o=0) until first result popped, then second result 24 appears next cycle with no loss.
- WEIGHT_SHARED=0, MAC_NUM=8: lane i din=i, weight=-1, ACC_LEN=1 -> out lane i = -i every beat; 1-per-cycle throughput with out_ready_i=1.
- clear_i after 2 of 4 beats, then 4 fresh beats of 1x1 -> result 4 (stale partial sum discarded); a previously pending result is unaffected by the clear.
- PU_SAT_EN, OUT_WIDTH=8, SHIFT=0: din 127, weight 127, ACC_LEN=2 -> lane 127 and sat_o=1. Same stimulus without the macro -> low 8 bits of 32258 (0x02), sat_o=0.
- Assert rst_i mid-block (after beat 2) with a result pending -> out_valid_o=0, out_data_o=0 immediately. Next full block after release yields a correct result.

Source files
------------

// File: rtl/pu_pkg.sv
// pu_pkg: shared types and helper functions for the pu_stream_array block.
//   pu_state_e      - accumulation FSM state (S_IDLE, S_ACCUM)
//   pu_cnt_width    - beat counter width for a given accumulation length (min 1)
//   pu_requant      - arithmetic right shift then optional saturation to out_w bits
//   pu_clipped      - reports whether pu_requant with saturation would clip
// Values are carried at REQ_W bits, so ACC_WIDTH must not exceed REQ_W.
package pu_pkg;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } pu_state_e;

  localparam int REQ_W = 64;

  function automatic int pu_cnt_width(input int len);
    int w;
    w = $clog2(len);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  // Shifted value; clipped to the signed out_w range when sat_en is set.
  // The caller keeps the low out_w bits, which is plain truncation otherwise.
  function automatic logic [REQ_W-1:0] pu_requant(input logic signed [REQ_W-1:0] value,
                                                  input int shift, input int out_w,
                                                  input bit sat_en);
    logic signed [REQ_W-1:0] shifted;
    logic signed [REQ_W-1:0] hi;
    logic signed [REQ_W-1:0] lo;
    logic signed [REQ_W-1:0] res;
    shifted = value >>> shift;
    hi      = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (out_w - 1));
    if (sat_en && (shifted > hi)) begin
      res = hi;
    end else if (sat_en && (shifted < lo)) begin
      res = lo;
    end else begin
      res = shifted;
    end
    return res;
  endfunction

  function automatic logic pu_clipped(input logic signed [REQ_W-1:0] value,
                                      input int shift, input int out_w);
    logic signed [REQ_W-1:0] shifted;
    logic signed [REQ_W-1:0] hi;
    logic signed [REQ_W-1:0] lo;
    shifted = value >>> shift;
    hi      = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (out_w - 1));
    return (shifted > hi) || (shifted < lo);
  endfunction

endpackage

// File: rtl/pu_lane.sv
// pu_lane: one signed multiply-accumulate lane.
//   clk, rst   - clock, asynchronous active-high reset
//   clear      - synchronous clear of the accumulator
//   beat       - an input beat is accepted this cycle
//   last       - the accepted beat closes the block (accumulator returns to 0)
//   din, win   - signed activation and weight
//   acc_sum    - accumulator plus current product (the value a closing beat produces)
module pu_lane #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    beat,
  input  logic                    last,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic [WEIGHT_WIDTH-1:0] win,
  output logic [ACC_WIDTH-1:0]    acc_sum
);

  localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;

  logic signed [DATA_WIDTH-1:0]   din_s;
  logic signed [WEIGHT_WIDTH-1:0] win_s;
  logic signed [PW-1:0]           prod_s;
  logic signed [ACC_WIDTH-1:0]    prod_ext_s;
  logic signed [ACC_WIDTH-1:0]    sum_s;
  logic signed [ACC_WIDTH-1:0]    acc_r;

  assign din_s      = din;
  assign win_s      = win;
  // Operands are sign-extended to the full product width before multiplying.
  assign prod_s     = PW'(din_s) * PW'(win_s);
  assign prod_ext_s = ACC_WIDTH'(prod_s);
  // Two's complement wrap at ACC_WIDTH is intentional.
  assign sum_s      = acc_r + prod_ext_s;
  assign acc_sum    = sum_s;

  // Accumulator: cleared, reloaded with zero on the closing beat, or summed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= {ACC_WIDTH{1'b0}};
    end else if (clear) begin
      acc_r <= {ACC_WIDTH{1'b0}};
    end else if (beat && last) begin
      acc_r <= {ACC_WIDTH{1'b0}};
    end else if (beat) begin
      acc_r <= sum_s;
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule

// File: rtl/pu_stream_array.sv
// pu_stream_array: MAC_NUM parallel signed MAC lanes summing ACC_LEN beats per
// result, with a one-entry output buffer and shift requantisation.
// Optional macro PU_SAT_EN: saturate each lane to OUT_WIDTH signed range and
// flag clipping on sat_o; without it results are truncated and sat_o is 0.
// Ports:
//   clk_i, rst_i            - clock, asynchronous active-high reset
//   en_i, clear_i           - global enable, synchronous accumulator clear
//   in_valid_i/in_ready_o   - input beat handshake (din_i, win_i)
//   out_valid_o/out_ready_i - result handshake (out_data_o, sat_o)
//   busy_o                  - FSM is in S_ACCUM
module pu_stream_array
  import pu_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int MAC_NUM       = 8,
  parameter int ACC_WIDTH     = 32,
  parameter int OUT_WIDTH     = 16,
  parameter int ACC_LEN       = 16,
  parameter int SHIFT         = 0,
  parameter int WEIGHT_SHARED = 1
) (
  input  logic                                                   clk_i,
  input  logic                                                   rst_i,
  input  logic                                                   en_i,
  input  logic                                                   clear_i,
  input  logic                                                   in_valid_i,
  output logic                                                   in_ready_o,
  input  logic [DATA_WIDTH*MAC_NUM-1:0]                          din_i,
  input  logic [WEIGHT_WIDTH*(WEIGHT_SHARED != 0 ? 1 : MAC_NUM)-1:0] win_i,
  output logic                                                   out_valid_o,
  input  logic                                                   out_ready_i,
  output logic [OUT_WIDTH*MAC_NUM-1:0]                           out_data_o,
  output logic [MAC_NUM-1:0]                                     sat_o,
  output logic                                                   busy_o
);

  localparam int              CNT_W    = pu_cnt_width(ACC_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);
`ifdef PU_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  pu_state_e                    state_r;
  pu_state_e                    state_n_s;
  logic [CNT_W-1:0]             cnt_r;
  logic [CNT_W-1:0]             cnt_n_s;
  logic                         last_beat_s;
  logic                         stall_s;
  logic                         in_ready_s;
  logic                         fire_s;
  logic                         push_s;
  logic                         pop_s;
  logic                         out_valid_r;
  logic [OUT_WIDTH*MAC_NUM-1:0] out_data_r;
  logic [OUT_WIDTH*MAC_NUM-1:0] res_data_s;

  assign last_beat_s = (cnt_r == CNT_LAST);
  // Only the closing beat needs the buffer; earlier beats flow regardless.
  assign stall_s     = last_beat_s & out_valid_r & ~out_ready_i;
  assign in_ready_s  = en_i & ~clear_i & ~stall_s;
  assign fire_s      = in_valid_i & in_ready_s;
  assign push_s      = fire_s & last_beat_s;
  assign pop_s       = out_valid_r & out_ready_i;

  assign in_ready_o  = in_ready_s;
  assign out_valid_o = out_valid_r;
  assign out_data_o  = out_data_r;
  assign busy_o      = (state_r == S_ACCUM);

  for (genvar i = 0; i < MAC_NUM; i++) begin : g_lane
    logic [WEIGHT_WIDTH-1:0]     w_s;
    logic signed [ACC_WIDTH-1:0] sum_s;
    logic [REQ_W-1:0]            q_s;

    if (WEIGHT_SHARED != 0) begin : g_shared
      assign w_s = win_i[WEIGHT_WIDTH-1:0];
    end else begin : g_own
      assign w_s = win_i[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end

    pu_lane #(
      .DATA_WIDTH  (DATA_WIDTH),
      .WEIGHT_WIDTH(WEIGHT_WIDTH),
      .ACC_WIDTH   (ACC_WIDTH)
    ) u_lane (
      .clk    (clk_i),
      .rst    (rst_i),
      .clear  (clear_i),
      .beat   (fire_s),
      .last   (last_beat_s),
      .din    (din_i[i*DATA_WIDTH +: DATA_WIDTH]),
      .win    (w_s),
      .acc_sum(sum_s)
    );

    assign q_s = pu_requant(REQ_W'(sum_s), SHIFT, OUT_WIDTH, SAT_EN);
    assign res_data_s[i*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(q_s);
  end

  // FSM and beat counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= S_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_n_s;
      cnt_r   <= cnt_n_s;
    end
  end

  // Next state and counter: clear wins, the closing beat rewinds, others count.
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    case (state_r)
      S_IDLE, S_ACCUM: begin
        if (clear_i) begin
          state_n_s = S_IDLE;
          cnt_n_s   = {CNT_W{1'b0}};
        end else if (push_s) begin
          state_n_s = S_IDLE;
          cnt_n_s   = {CNT_W{1'b0}};
        end else if (fire_s) begin
          state_n_s = S_ACCUM;
          cnt_n_s   = cnt_r + CNT_W'(1);
        end else begin
          state_n_s = state_r;
          cnt_n_s   = cnt_r;
        end
      end
      default: begin
        state_n_s = S_IDLE;
        cnt_n_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Output buffer: a push takes priority over a simultaneous pop (reload).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {(OUT_WIDTH*MAC_NUM){1'b0}};
    end else if (push_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= res_data_s;
    end else if (pop_s) begin
      out_valid_r <= 1'b0;
      out_data_r  <= out_data_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
    end
  end

`ifdef PU_SAT_EN
  logic [MAC_NUM-1:0] sat_r;
  logic [MAC_NUM-1:0] res_sat_s;

  for (genvar i = 0; i < MAC_NUM; i++) begin : g_sat
    assign res_sat_s[i] = pu_clipped(REQ_W'(g_lane[i].sum_s), SHIFT, OUT_WIDTH);
  end

  // Saturation flags travel with the buffered result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sat_r <= {MAC_NUM{1'b0}};
    end else if (push_s) begin
      sat_r <= res_sat_s;
    end else begin
      sat_r <= sat_r;
    end
  end

  assign sat_o = sat_r;
`else
  assign sat_o = {MAC_NUM{1'b0}};
`endif

endmodule
